seq_divider_32bit: RTL and testbench



---
 rtl/seq_divider_32bit.sv | 150 +++++++++++++++
 tb/tb_seq_divider_32bit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_32bit.sv
// seq_divider_32bit: multi-cycle 32-bit non-restoring divider, one quotient
// bit per clock, start/done handshake. Quotient feeds LO, remainder feeds HI.
// Optional feature macro: DIV_SIGNED_EN enables two's-complement operation
// selected by i_signed; when undefined every operation is unsigned.
module seq_divider_32bit (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [32:0] r_p;      // partial remainder, two's complement
    logic [31:0] r_q;      // dividend shifting out / quotient shifting in
    logic [31:0] r_d;      // divisor magnitude
    logic [5:0]  r_cnt;

    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [32:0] w_p_shift;
    logic [32:0] w_p_next;
    logic [31:0] w_rem_corr;
    logic [31:0] w_quo_res;
    logic [31:0] w_rem_res;

`ifdef DIV_SIGNED_EN
    logic        r_q_neg;
    logic        r_r_neg;
    logic        w_dvd_neg;
    logic        w_dvs_neg;

    assign w_dvd_neg = i_signed & i_dividend[31];
    assign w_dvs_neg = i_signed & i_divisor[31];
    assign w_dvd_mag = w_dvd_neg ? (32'd0 - i_dividend) : i_dividend;
    assign w_dvs_mag = w_dvs_neg ? (32'd0 - i_divisor)  : i_divisor;
`else
    logic        w_unused_signed;

    assign w_unused_signed = i_signed;
    assign w_dvd_mag       = i_dividend;
    assign w_dvs_mag       = i_divisor;
`endif

    // One non-restoring step: shift {P,Q} left, then subtract D when P was
    // non-negative, add D when it was negative.
    assign w_p_shift  = {r_p[31:0], r_q[31]};
    assign w_p_next   = r_p[32] ? (w_p_shift + {1'b0, r_d})
                                : (w_p_shift - {1'b0, r_d});

    // Final remainder correction; only the low 32 bits reach the output.
    assign w_rem_corr = r_p[32] ? (r_p[31:0] + r_d) : r_p[31:0];

`ifdef DIV_SIGNED_EN
    assign w_quo_res  = r_q_neg ? (32'd0 - r_q)        : r_q;
    assign w_rem_res  = r_r_neg ? (32'd0 - w_rem_corr) : w_rem_corr;
`else
    assign w_quo_res  = r_q;
    assign w_rem_res  = w_rem_corr;
`endif

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state       <= S_IDLE;
            r_p           <= '0;
            r_q           <= '0;
            r_d           <= '0;
            r_cnt         <= '0;
`ifdef DIV_SIGNED_EN
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
`endif
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        o_busy <= 1'b1;
                        if (i_divisor == 32'd0) begin
                            // Raw dividend parked in r_q; published from DONE.
                            r_q     <= i_dividend;
                            r_state <= S_DONE;
                        end else begin
                            r_q     <= w_dvd_mag;
                            r_d     <= w_dvs_mag;
                            r_p     <= '0;
                            r_cnt   <= '0;
`ifdef DIV_SIGNED_EN
                            r_q_neg <= w_dvd_neg ^ w_dvs_neg;
                            r_r_neg <= w_dvd_neg;
`endif
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_p   <= w_p_next;
                    r_q   <= {r_q[30:0], ~w_p_next[32]};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    o_quotient    <= w_quo_res;
                    o_remainder   <= w_rem_res;
                    o_div_by_zero <= 1'b0;
                    o_done        <= 1'b1;
                    r_state       <= S_DONE;
                end
                S_DONE: begin
                    // DONE entered with o_done low only on the divide-by-zero
                    // path: publish its results here, one cycle after start.
                    if (o_done) begin
                        o_done  <= 1'b0;
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        o_quotient    <= '1;
                        o_remainder   <= r_q;
                        o_div_by_zero <= 1'b1;
                        o_done        <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Self-checking bench for seq_divider_32bit: scoreboard of expected results
// pushed at start, popped when o_done is seen. Honours DIV_SIGNED_EN.
module tb_seq_divider_32bit;

    logic        clk;
    logic        clr_n;
    logic        i_start;
    logic        i_signed;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;
    logic        o_busy;
    logic        o_done;
    logic        o_div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_q = 32'd0;
    logic [31:0] last_r = 32'd0;

    seq_divider_32bit u_dut (
        .clk           (clk),
        .clr_n         (clr_n),
        .i_start       (i_start),
        .i_signed      (i_signed),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_div_by_zero (o_div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: expected quotient/remainder/flag/latency.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic s);
        exp_t   e;
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        e.dbz = 1'b0;
        e.lat = 33;
        if (b == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            sa = longint'(a);
            sb = longint'(b);
`ifdef DIV_SIGNED_EN
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end
`else
            if (s) sa = longint'(a);
`endif
            lq  = sa / sb;
            lr  = sa % sb;
            e.q = lq[31:0];
            e.r = lr[31:0];
        end
        return e;
    endfunction

    // Drive one divide and check it; inject_at pulses a stray start at that
    // cycle count, reset_at aborts with clr_n at that cycle count (0 = never).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic s, input string name,
                           input int inject_at, input int reset_at);
        exp_t e;
        int   n;
        bit   seen;
        bit   bad;
        sb_q.push_back(model(a, b, s));
        @(negedge clk);
        i_start    = 1'b1;
        i_dividend = a;
        i_divisor  = b;
        i_signed   = s;
        @(posedge clk);
        #1;
        i_start    = 1'b0;
        i_dividend = $urandom;
        i_divisor  = $urandom;
        i_signed   = 1'($urandom);
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_rise: got %b want 1", name, o_busy);
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = (o_done === 1'b1);
            if (n == 16 && b != 32'd0) begin
                n_cmp++;
                if (o_quotient !== last_q || o_remainder !== last_r) begin
                    n_err++;
                    $display("FAIL %s hold_mid_run: got q=%h r=%h want q=%h r=%h",
                             name, o_quotient, o_remainder, last_q, last_r);
                end
            end
            if (n == inject_at) begin
                i_start    = 1'b1;
                i_dividend = 32'd1000;
                i_divisor  = 32'd3;
            end
            if (n == inject_at + 1) i_start = 1'b0;
            if (n == reset_at) begin
                clr_n = 1'b0;
                #1;
                n_cmp++;
                if (o_quotient !== 32'd0 || o_remainder !== 32'd0 || o_busy !== 1'b0 ||
                    o_done !== 1'b0 || o_div_by_zero !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b want all 0",
                             name, o_quotient, o_remainder, o_busy, o_done, o_div_by_zero);
                end
                void'(sb_q.pop_back());
                last_q = 32'd0;
                last_r = 32'd0;
                repeat (3) @(negedge clk);
                clr_n = 1'b1;
                bad = 1'b0;
                repeat (40) begin
                    @(negedge clk);
                    if (o_done !== 1'b0 || o_busy !== 1'b0) bad = 1'b1;
                end
                n_cmp++;
                if (bad) begin
                    n_err++;
                    $display("FAIL %s no_done_after_abort: got done/busy activity want none", name);
                end
                return;
            end
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s timeout: got no o_done within %0d cycles want %0d", name, n, e.lat);
            return;
        end
        n_cmp++;
        if (n != e.lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, n, e.lat);
        end
        n_cmp++;
        if (o_quotient !== e.q) begin
            n_err++;
            $display("FAIL %s quotient: got %h want %h", name, o_quotient, e.q);
        end
        n_cmp++;
        if (o_remainder !== e.r) begin
            n_err++;
            $display("FAIL %s remainder: got %h want %h", name, o_remainder, e.r);
        end
        n_cmp++;
        if (o_div_by_zero !== e.dbz) begin
            n_err++;
            $display("FAIL %s div_by_zero: got %b want %b", name, o_div_by_zero, e.dbz);
        end
        last_q = e.q;
        last_r = e.r;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_quotient !== e.q || o_remainder !== e.r) begin
            n_err++;
            $display("FAIL %s done_pulse_end: got done=%b busy=%b q=%h r=%h want 0 0 %h %h",
                     name, o_done, o_busy, o_quotient, o_remainder, e.q, e.r);
        end
    endtask

    task automatic test_reset();
        clr_n      = 1'b0;
        i_start    = 1'b0;
        i_signed   = 1'b0;
        i_dividend = 32'd0;
        i_divisor  = 32'd0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (o_quotient !== 32'd0 || o_remainder !== 32'd0 || o_busy !== 1'b0 ||
            o_done !== 1'b0 || o_div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b dbz=%b want all 0",
                     o_quotient, o_remainder, o_busy, o_done, o_div_by_zero);
        end
        clr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        run_div(32'd100,       32'd7,        1'b0, "u_100_7",   0, 0);
        run_div(32'hFFFF_FFFF, 32'd1,        1'b0, "u_max_1",   0, 0);
        run_div(32'd3,         32'd5,        1'b0, "u_3_5",     0, 0);
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_max_max", 0, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_min_max", 0, 0);
    endtask

    task automatic test_div_by_zero();
        run_div(32'd5, 32'd0, 1'b0, "dbz_5_0", 0, 0);
        run_div(32'd9, 32'd3, 1'b0, "after_dbz_9_3", 0, 0);
        run_div(32'hFFFF_FFF9, 32'd0, 1'b1, "dbz_signed", 0, 0);
    endtask

    task automatic test_signed();
        run_div(32'hFFFF_FFF9, 32'd2,         1'b1, "s_m7_2",     0, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_min_m1",   0, 0);
        run_div(32'd7,         32'hFFFF_FFFE, 1'b1, "s_7_m2",     0, 0);
        run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, "s_m100_m7",  0, 0);
    endtask

    task automatic test_ignore_start();
        run_div(32'd100, 32'd7, 1'b0, "ignore_start", 5, 0);
    endtask

    task automatic test_mid_reset();
        run_div(32'd100, 32'd7, 1'b0, "mid_reset", 0, 10);
        run_div(32'd100, 32'd7, 1'b0, "after_reset_100_7", 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? ($urandom >> (i * 4)) : 32'($urandom_range(1, 300));
            if (b == 32'd0) b = 32'd13;
            run_div(a, b, 1'(i % 3 == 0), $sformatf("b2b_%0d", i), 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_div_by_zero();
        test_signed();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
